// File: rtl/ifm_pingpong_bank_buffer_if.sv
// Loader/consumer signal bundle for the ping-pong banked IFM buffer.
// The master side is the loader plus array feeder; the slave side is the buffer itself.
interface ifm_pingpong_bank_buffer_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_BANKS  = 16,
   parameter int unsigned DEPTH      = 4096
);
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

   logic                             wr_valid;
   logic                             wr_ready;
   logic [ADDR_WIDTH-1:0]            wr_addr;
   logic [NUM_BANKS-1:0]             wr_bank_en;
   logic [DATA_WIDTH*NUM_BANKS-1:0]  wr_data;
   logic                             wr_last;
   logic                             rd_en;
   logic [ADDR_WIDTH*NUM_BANKS-1:0]  rd_addr;
   logic                             rd_done;
   logic [DATA_WIDTH*NUM_BANKS-1:0]  rd_data;
   logic                             rd_valid;
   logic                             tile_avail;
   logic                             wr_sel;
   logic                             rd_sel;
   logic                             err;

   modport master (
      output wr_valid, wr_addr, wr_bank_en, wr_data, wr_last, rd_en, rd_addr, rd_done,
      input  wr_ready, rd_data, rd_valid, tile_avail, wr_sel, rd_sel, err
   );

   modport slave (
      input  wr_valid, wr_addr, wr_bank_en, wr_data, wr_last, rd_en, rd_addr, rd_done,
      output wr_ready, rd_data, rd_valid, tile_avail, wr_sel, rd_sel, err
   );
endinterface

// File: rtl/ifm_pingpong_bank_buffer.sv
// Double-buffered banked IFM store: loader fills one half while the array drains the other.
// Define IFM_BUF_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module ifm_pingpong_bank_buffer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_BANKS  = 16,
   parameter int unsigned DEPTH      = 4096
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   ifm_pingpong_bank_buffer_if.slave bus
);
   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

   logic [1:0] r_full;
   logic [1:0] w_full_next;
   logic       r_wr_sel;
   logic       w_wr_sel_next;
   logic       r_rd_sel;
   logic       w_rd_sel_next;
   logic       r_err;
   logic       w_err_next;

   logic       w_wr_ready;
   logic       w_tile_avail;
   logic       w_wr_fire;
   logic       w_fill_done;
   logic       w_release;
   logic       w_rd_fire;

   logic                            r_rd_valid_s1;
   logic [DATA_WIDTH*NUM_BANKS-1:0] w_rd_data_s1;

   assign w_wr_ready   = ~r_full[r_wr_sel];
   assign w_tile_avail = r_full[r_rd_sel];
   assign w_wr_fire    = bus.wr_valid & w_wr_ready;
   assign w_fill_done  = w_wr_fire & bus.wr_last;
   assign w_release    = bus.rd_done & w_tile_avail;
   assign w_rd_fire    = bus.rd_en & w_tile_avail;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full   <= 2'b00;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_full   <= w_full_next;
         r_wr_sel <= w_wr_sel_next;
         r_rd_sel <= w_rd_sel_next;
         r_err    <= w_err_next;
      end
   end

   // A completing fill needs its half empty and a release needs its half full,
   // so the two updates below can never target the same half.
   always_comb begin
      w_full_next   = r_full;
      w_wr_sel_next = r_wr_sel;
      w_rd_sel_next = r_rd_sel;
      w_err_next    = r_err | ((bus.rd_en | bus.rd_done) & ~w_tile_avail);
      if (w_fill_done) begin
         w_full_next[r_wr_sel] = 1'b1;
         w_wr_sel_next         = ~r_wr_sel;
      end
      if (w_release) begin
         w_full_next[r_rd_sel] = 1'b0;
         w_rd_sel_next         = ~r_rd_sel;
      end
   end

   always_comb begin
      bus.wr_ready   = w_wr_ready;
      bus.tile_avail = w_tile_avail;
      bus.wr_sel     = r_wr_sel;
      bus.rd_sel     = r_rd_sel;
      bus.err        = r_err;
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];
      logic [DATA_WIDTH-1:0] r_rd_word;
      logic [ADDR_WIDTH-1:0] w_rd_addr;

      assign w_rd_addr = bus.rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];

      // Storage is deliberately not reset so it maps onto block RAM.
      always_ff @(posedge i_clk) begin
         if (w_wr_fire && bus.wr_bank_en[g]) begin
            r_mem[{r_wr_sel, bus.wr_addr}] <= bus.wr_data[g*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_rd_word <= '0;
         end else if (w_rd_fire) begin
            r_rd_word <= r_mem[{r_rd_sel, w_rd_addr}];
         end
      end

      assign w_rd_data_s1[g*DATA_WIDTH +: DATA_WIDTH] = r_rd_word;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_valid_s1 <= 1'b0;
      end else begin
         r_rd_valid_s1 <= w_rd_fire;
      end
   end

`ifdef IFM_BUF_OUT_REG_EN
   logic                            r_rd_valid_s2;
   logic [DATA_WIDTH*NUM_BANKS-1:0] r_rd_data_s2;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_valid_s2 <= 1'b0;
         r_rd_data_s2  <= '0;
      end else begin
         r_rd_valid_s2 <= r_rd_valid_s1;
         if (r_rd_valid_s1) begin
            r_rd_data_s2 <= w_rd_data_s1;
         end
      end
   end

   assign bus.rd_valid = r_rd_valid_s2;
   assign bus.rd_data  = r_rd_data_s2;
`else
   assign bus.rd_valid = r_rd_valid_s1;
   assign bus.rd_data  = w_rd_data_s1;
`endif
endmodule

// File: tb/tb_ifm_pingpong_bank_buffer.sv
// Self-checking bench for ifm_pingpong_bank_buffer: directed ping-pong fill/read/release
// scenarios checked every cycle against a behavioural model, plus literal spot checks.
module tb_ifm_pingpong_bank_buffer;
   localparam int DW = 8;
   localparam int NB = 16;
   localparam int DEPTH = 4096;
   localparam int AW = $clog2(DEPTH);
`ifdef IFM_BUF_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   ifm_pingpong_bank_buffer_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .DEPTH(DEPTH)) bus ();

   ifm_pingpong_bank_buffer #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .DEPTH(DEPTH)) u_dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: two halves of per-bank memory, a full flag per half, and a
   // delay line of LAT read results.
   logic [7:0]   m_mem [2][NB][DEPTH];
   logic [1:0]   m_full;
   logic         m_wr_sel;
   logic         m_rd_sel;
   logic         m_err;
   logic         m_live;
   logic         pipe_v [LAT];
   logic [127:0] pipe_d [LAT];

   initial begin
      m_live = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_full   = 2'b00;
            m_wr_sel = 1'b0;
            m_rd_sel = 1'b0;
            m_err    = 1'b0;
            for (int k = 0; k < LAT; k++) begin
               pipe_v[k] = 1'b0;
               pipe_d[k] = '0;
            end
            m_live = 1'b1;
         end else if (m_live) begin
            logic         avail;
            logic         can_wr;
            logic         ws;
            logic         rs;
            logic         new_v;
            logic [127:0] new_d;
            ws     = m_wr_sel;
            rs     = m_rd_sel;
            avail  = m_full[rs];
            can_wr = !m_full[ws];
            new_v  = bus.rd_en && avail;
            new_d  = '0;
            if (new_v) begin
               for (int i = 0; i < NB; i++) begin
                  new_d[i*DW +: DW] = m_mem[rs][i][int'(bus.rd_addr[i*AW +: AW])];
               end
            end
            if ((bus.rd_en || bus.rd_done) && !avail) m_err = 1'b1;
            if (bus.wr_valid && can_wr) begin
               for (int i = 0; i < NB; i++) begin
                  if (bus.wr_bank_en[i]) m_mem[ws][i][int'(bus.wr_addr)] = bus.wr_data[i*DW +: DW];
               end
               if (bus.wr_last) begin
                  m_full[ws] = 1'b1;
                  m_wr_sel   = !ws;
               end
            end
            if (bus.rd_done && avail) begin
               m_full[rs] = 1'b0;
               m_rd_sel   = !rs;
            end
            for (int k = LAT - 1; k > 0; k--) begin
               pipe_v[k] = pipe_v[k-1];
               pipe_d[k] = pipe_d[k-1];
            end
            pipe_v[0] = new_v;
            pipe_d[0] = new_d;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            chk("wr_ready", 128'(bus.wr_ready), 128'(!m_full[m_wr_sel]));
            chk("tile_avail", 128'(bus.tile_avail), 128'(m_full[m_rd_sel]));
            chk("wr_sel", 128'(bus.wr_sel), 128'(m_wr_sel));
            chk("rd_sel", 128'(bus.rd_sel), 128'(m_rd_sel));
            chk("err", 128'(bus.err), 128'(m_err));
            chk("rd_valid", 128'(bus.rd_valid), 128'(pipe_v[LAT-1]));
            if (pipe_v[LAT-1]) chk("rd_data", bus.rd_data, pipe_d[LAT-1]);
         end
      end
   end

   task automatic idle();
      bus.wr_valid   = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_bank_en = '0;
      bus.wr_data    = '0;
      bus.wr_last    = 1'b0;
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
      bus.rd_done    = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic fill_beat(input int a, input logic [7:0] base, input logic last);
      bus.wr_valid   = 1'b1;
      bus.wr_addr    = AW'(a);
      bus.wr_bank_en = '1;
      bus.wr_last    = last;
      for (int i = 0; i < NB; i++) bus.wr_data[i*DW +: DW] = base + 8'(16 * a + i);
   endtask

   task automatic rd_mod4();
      bus.rd_en = 1'b1;
      for (int i = 0; i < NB; i++) bus.rd_addr[i*AW +: AW] = AW'(i % 4);
   endtask

   // Bounded wait for rd_valid; returns the number of cycles since the read issued.
   task automatic wait_valid(output int k);
      k = 1;
      while (!bus.rd_valid && k < 6) begin
         tick();
         k++;
      end
   endtask

   initial begin
      int k;
      n_checks = 0;
      n_errors = 0;
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_wr_ready", 128'(bus.wr_ready), 128'd1);
      chk("reset_tile_avail", 128'(bus.tile_avail), 128'd0);
      chk("reset_sels", 128'({bus.wr_sel, bus.rd_sel}), 128'd0);
      chk("reset_err", 128'(bus.err), 128'd0);
      chk("reset_rd_valid", 128'(bus.rd_valid), 128'd0);
      chk("reset_rd_data", bus.rd_data, 128'd0);

      // Fill half 0
      for (int a = 0; a < 4; a++) begin
         idle();
         fill_beat(a, 8'h00, a == 3);
         tick();
      end
      idle();
      chk("t1_tile_avail", 128'(bus.tile_avail), 128'd1);
      chk("t1_wr_sel", 128'(bus.wr_sel), 128'd1);
      chk("t1_rd_sel", 128'(bus.rd_sel), 128'd0);

      // Skewed read of half 0
      rd_mod4();
      tick();
      idle();
      wait_valid(k);
      chk("t2_latency", 128'(k), 128'(LAT));
      chk("t2_bank5", 128'(bus.rd_data[5*DW +: DW]), 128'h15);
      chk("t2_bank15", 128'(bus.rd_data[15*DW +: DW]), 128'h3F);

      // Fill half 1 while reading half 0
      for (int a = 0; a < 4; a++) begin
         idle();
         fill_beat(a, 8'h80, a == 3);
         rd_mod4();
         tick();
      end
      idle();
      chk("t3_both_full_wr_ready", 128'(bus.wr_ready), 128'd0);
      bus.rd_done = 1'b1;
      tick();
      idle();
      chk("t3_rd_sel", 128'(bus.rd_sel), 128'd1);
      chk("t3_wr_ready", 128'(bus.wr_ready), 128'd1);
      rd_mod4();
      tick();
      idle();
      wait_valid(k);
      chk("t3_bank0", 128'(bus.rd_data[0 +: DW]), 128'h80);
      chk("t3_bank5", 128'(bus.rd_data[5*DW +: DW]), 128'h95);

      // Bank-masked overwrite into half 0
      bus.wr_valid   = 1'b1;
      bus.wr_addr    = AW'(2);
      bus.wr_bank_en = 16'h0001;
      bus.wr_data    = '1;
      bus.wr_last    = 1'b1;
      tick();
      idle();
      chk("t4_both_full_wr_ready", 128'(bus.wr_ready), 128'd0);
      bus.rd_done = 1'b1;
      tick();
      idle();
      chk("t4_rd_sel", 128'(bus.rd_sel), 128'd0);
      bus.rd_en = 1'b1;
      for (int i = 0; i < NB; i++) bus.rd_addr[i*AW +: AW] = AW'(2);
      tick();
      idle();
      wait_valid(k);
      chk("t4_bank0", 128'(bus.rd_data[0 +: DW]), 128'hFF);
      chk("t4_bank3", 128'(bus.rd_data[3*DW +: DW]), 128'h23);
      chk("t4_bank15", 128'(bus.rd_data[15*DW +: DW]), 128'h2F);

      // Read and release with no tile available
      bus.rd_done = 1'b1;
      tick();
      idle();
      chk("t5_tile_avail", 128'(bus.tile_avail), 128'd0);
      rd_mod4();
      tick();
      idle();
      for (int c = 0; c < LAT + 2; c++) begin
         chk("t5_no_rd_valid", 128'(bus.rd_valid), 128'd0);
         chk("t5_err_sticky", 128'(bus.err), 128'd1);
         tick();
      end
      bus.rd_done = 1'b1;
      tick();
      idle();
      chk("t5_rd_sel_unchanged", 128'(bus.rd_sel), 128'd1);

      // Reset, then concurrent fill completion and release
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_err_cleared", 128'(bus.err), 128'd0);
      for (int a = 0; a < 4; a++) begin
         idle();
         fill_beat(a, 8'h40, a == 3);
         tick();
      end
      for (int a = 0; a < 3; a++) begin
         idle();
         fill_beat(a, 8'hC0, 1'b0);
         tick();
      end
      idle();
      fill_beat(3, 8'hC0, 1'b1);
      rd_mod4();
      bus.rd_done = 1'b1;
      tick();
      idle();
      chk("t6_wr_sel", 128'(bus.wr_sel), 128'd0);
      chk("t6_rd_sel", 128'(bus.rd_sel), 128'd1);
      chk("t6_full_10", 128'({bus.tile_avail, bus.wr_ready}), 128'b11);
      wait_valid(k);
      chk("t6_old_half_bank5", 128'(bus.rd_data[5*DW +: DW]), 128'h55);

      // Reset with reads in flight
      idle();
      rd_mod4();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      for (int c = 0; c < LAT + 1; c++) begin
         chk("t6_flushed_rd_valid", 128'(bus.rd_valid), 128'd0);
         tick();
      end
      chk("t6_rst_flags",
          128'({bus.wr_ready, bus.tile_avail, bus.wr_sel, bus.rd_sel, bus.err}), 128'b10000);
      chk("t6_rst_rd_data", bus.rd_data, 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
